// File: rtl/bridge_router.sv
`default_nettype none
// ============================================================================
// Module   : bridge_router
// Purpose  : Decodes the APF bridge bus onto NUM_LEAVES leaves using
//            per-leaf inclusive address ranges. Leaf strobes, the broadcast
//            address and the write data are registered. Read returns go
//            through a pipeline that matches the programmable leaf read
//            latency. Accesses that hit no leaf return UNMAPPED_DATA and
//            are counted, and the most recent miss address is recorded.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   bridge clock (clk_74a domain)
//   reset               in   synchronous active-high reset
//   bridge_addr         in   ADDR_W      bridge address
//   bridge_wr           in   1           write strobe (single cycle)
//   bridge_wr_data      in   DATA_W      write data
//   bridge_rd           in   1           read strobe (single cycle)
//   bridge_rd_data      out  DATA_W      registered read return
//   leaf_addr           out  ADDR_W      registered broadcast address
//   leaf_wr_data        out  DATA_W      registered broadcast write data
//   leaf_wr             out  NUM_LEAVES  one-hot write strobes
//   leaf_rd             out  NUM_LEAVES  one-hot read strobes
//   leaf_rd_data        in   NUM_LEAVES*DATA_W, leaf i in slice i
//   unmapped_count      out  ERR_CNT_W   saturating unmapped-access count
//   last_unmapped_addr  out  ADDR_W      most recent unmapped address
// ----------------------------------------------------------------------------
// Build option
//   BRIDGE_ROUTER_BYTESWAP_EN : when defined, write data and captured read
//   data (UNMAPPED_DATA included) are byte-reversed. Address is untouched.
// ============================================================================
module bridge_router #(
  parameter int                           NUM_LEAVES    = 6,
  parameter int                           ADDR_W        = 32,
  parameter int                           DATA_W        = 32,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] ADDR_FROM     = '0,
  parameter logic [NUM_LEAVES*ADDR_W-1:0] ADDR_TO       = '0,
  parameter int                           READ_LATENCY  = 2,
  parameter logic [DATA_W-1:0]            UNMAPPED_DATA = '0,
  parameter int                           ERR_CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            bridge_addr,
  input  logic                         bridge_wr,
  input  logic [DATA_W-1:0]            bridge_wr_data,
  input  logic                         bridge_rd,
  output logic [DATA_W-1:0]            bridge_rd_data,
  output logic [ADDR_W-1:0]            leaf_addr,
  output logic [DATA_W-1:0]            leaf_wr_data,
  output logic [NUM_LEAVES-1:0]        leaf_wr,
  output logic [NUM_LEAVES-1:0]        leaf_rd,
  input  logic [NUM_LEAVES*DATA_W-1:0] leaf_rd_data,
  output logic [ERR_CNT_W-1:0]         unmapped_count,
  output logic [ADDR_W-1:0]            last_unmapped_addr
);

  localparam int IDX_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
  localparam int RL    = READ_LATENCY;

  function automatic logic [DATA_W-1:0] f_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
`ifdef BRIDGE_ROUTER_BYTESWAP_EN
    for (int b = 0; b < DATA_W/8; b++) begin
      r[b*8 +: 8] = d[(DATA_W/8-1-b)*8 +: 8];
    end
`else
    r = d;
`endif
    return r;
  endfunction

  // Address decode
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Walk downward so the lowest matching index is the one left standing.
    for (int i = NUM_LEAVES-1; i >= 0; i--) begin
      if ((bridge_addr >= ADDR_FROM[i*ADDR_W +: ADDR_W]) &&
          (bridge_addr <= ADDR_TO[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Registered state
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_LEAVES-1:0] wr_q, wr_d;
  logic [NUM_LEAVES-1:0] rd_q, rd_d;
  logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]     last_q, last_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  // Read tracking pipeline: stage 0 launches alongside leaf_rd, stage RL
  // lines up with the cycle in which the leaf presents its data.
  logic [RL:0]      vld_q;
  logic [RL:0]      unm_q;
  logic [IDX_W-1:0] idx_q [RL:0];

  logic             miss;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    miss     = (bridge_wr | bridge_rd) & ~hit;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = '0;
    rd_d     = '0;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    sel_data = '0;

    if (bridge_wr | bridge_rd) begin
      addr_d  = bridge_addr;
      wdata_d = f_swap(bridge_wr_data);
    end

    for (int i = 0; i < NUM_LEAVES; i++) begin
      wr_d[i] = bridge_wr & hit & (hit_idx == IDX_W'(i));
      rd_d[i] = bridge_rd & hit & (hit_idx == IDX_W'(i));
      if (idx_q[RL] == IDX_W'(i)) begin
        sel_data = leaf_rd_data[i*DATA_W +: DATA_W];
      end
    end

    // One increment per cycle even if both strobes miss.
    if (miss) begin
      last_d = bridge_addr;
      if (cnt_q != {ERR_CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (vld_q[RL]) begin
      rdata_d = unm_q[RL] ? f_swap(UNMAPPED_DATA) : f_swap(sel_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      rdata_q <= '0;
      vld_q   <= '0;
      unm_q   <= '0;
      for (int k = 0; k <= RL; k++) begin
        idx_q[k] <= '0;
      end
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rdata_q  <= rdata_d;
      vld_q[0] <= bridge_rd;
      unm_q[0] <= ~hit;
      idx_q[0] <= hit_idx;
      for (int k = 1; k <= RL; k++) begin
        vld_q[k] <= vld_q[k-1];
        unm_q[k] <= unm_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  assign bridge_rd_data     = rdata_q;
  assign leaf_addr          = addr_q;
  assign leaf_wr_data       = wdata_q;
  assign leaf_wr            = wr_q;
  assign leaf_rd            = rd_q;
  assign unmapped_count     = cnt_q;
  assign last_unmapped_addr = last_q;

endmodule
`default_nettype wire

// File: tb/tb_bridge_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_bridge_router
// Purpose  : Self-checking bench for bridge_router. Directed scenarios plus
//            random traffic, compared every cycle against a transaction-level
//            model (first-match range lookup, queue of outstanding reads).
// Revision : 1.0  initial release
// ============================================================================
module tb_bridge_router;

  localparam int N    = 6;
  localparam int RL   = 2;
  localparam int ECW  = 2;
  localparam logic [31:0] UNMAP = 32'h0000_0000;
  localparam logic [N*32-1:0] P_FROM = {32'h1000_1620, 32'h0010_0000, 32'h0000_0000,
                                        32'hF800_2380, 32'hF800_2000, 32'hF800_0000};
  localparam logic [N*32-1:0] P_TO   = {32'h1000_166F, 32'h0010_0000, 32'h000F_FFFF,
                                        32'hF800_23FF, 32'hF800_20FF, 32'hF800_1FFF};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     bridge_addr = '0;
  logic            bridge_wr = 1'b0;
  logic [31:0]     bridge_wr_data = '0;
  logic            bridge_rd = 1'b0;
  logic [31:0]     bridge_rd_data;
  logic [31:0]     leaf_addr;
  logic [31:0]     leaf_wr_data;
  logic [N-1:0]    leaf_wr;
  logic [N-1:0]    leaf_rd;
  logic [N*32-1:0] leaf_rd_data = '0;
  logic [ECW-1:0]  unmapped_count;
  logic [31:0]     last_unmapped_addr;

  bridge_router #(
    .NUM_LEAVES(N), .ADDR_W(32), .DATA_W(32),
    .ADDR_FROM(P_FROM), .ADDR_TO(P_TO),
    .READ_LATENCY(RL), .UNMAPPED_DATA(UNMAP), .ERR_CNT_W(ECW)
  ) dut (
    .clk(clk), .reset(reset),
    .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
    .bridge_rd_data(bridge_rd_data), .leaf_addr(leaf_addr),
    .leaf_wr_data(leaf_wr_data), .leaf_wr(leaf_wr), .leaf_rd(leaf_rd),
    .leaf_rd_data(leaf_rd_data), .unmapped_count(unmapped_count),
    .last_unmapped_addr(last_unmapped_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
`ifdef BRIDGE_ROUTER_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // First leaf whose inclusive range contains a, or -1.
  function automatic int lookup(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (a >= P_FROM[i*32 +: 32] && a <= P_TO[i*32 +: 32]) return i;
    return -1;
  endfunction

  // Expected visible outputs for the current cycle
  logic [N-1:0] e_wr = '0, e_rd = '0;
  logic [31:0]  e_addr = '0, e_wd = '0, e_rdata = '0, e_last = '0;
  int           e_cnt = 0;

  typedef struct { int due; int idx; } pend_t;
  pend_t pq[$];

  // Drives one cycle of inputs, advances the model, checks the outputs
  // produced by the previous cycle, then moves to the next cycle.
  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0]  ld [N];
    logic [N-1:0] n_wr, n_rd;
    logic [31:0]  n_addr, n_wd, n_rdata, n_last;
    int           n_cnt, h;
    reset = r; bridge_wr = w; bridge_rd = rd; bridge_addr = a; bridge_wr_data = d;
    for (int i = 0; i < N; i++) begin
      ld[i] = $urandom;
      leaf_rd_data[i*32 +: 32] = ld[i];
    end
    if (r) begin
      n_wr = '0; n_rd = '0; n_addr = '0; n_wd = '0; n_rdata = '0; n_last = '0; n_cnt = 0;
      pq.delete();
    end else begin
      n_wr = '0; n_rd = '0; n_addr = e_addr; n_wd = e_wd;
      n_rdata = e_rdata; n_last = e_last; n_cnt = e_cnt;
      h = lookup(a);
      if (w || rd) begin
        n_addr = a;
        n_wd   = bswap(d);
        if (h < 0) begin
          n_last = a;
          if (n_cnt < (1 << ECW) - 1) n_cnt++;
        end
      end
      if (w && h >= 0) n_wr[h] = 1'b1;
      if (rd && h >= 0) n_rd[h] = 1'b1;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        n_rdata = (pq[0].idx < 0) ? bswap(UNMAP) : bswap(ld[pq[0].idx]);
        void'(pq.pop_front());
      end
      if (rd) pq.push_back('{due: cyc + 1 + RL, idx: h});
    end
    @(negedge clk);
    check("leaf_wr",   64'(leaf_wr),            64'(e_wr));
    check("leaf_rd",   64'(leaf_rd),            64'(e_rd));
    check("leaf_addr", 64'(leaf_addr),          64'(e_addr));
    check("leaf_wd",   64'(leaf_wr_data),       64'(e_wd));
    check("rd_data",   64'(bridge_rd_data),     64'(e_rdata));
    check("unm_cnt",   64'(unmapped_count),     64'(e_cnt));
    check("unm_addr",  64'(last_unmapped_addr), 64'(e_last));
    @(posedge clk);
    #1;
    e_wr = n_wr; e_rd = n_rd; e_addr = n_addr; e_wd = n_wd;
    e_rdata = n_rdata; e_last = n_last; e_cnt = n_cnt;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] pick_addr();
    int l;
    logic [31:0] lo, hi;
    l  = int'($urandom_range(N-1, 0));
    lo = P_FROM[l*32 +: 32];
    hi = P_TO[l*32 +: 32];
    case ($urandom_range(5, 0))
      0: return lo + ($urandom % (hi - lo + 32'd1));
      1: return lo;
      2: return hi;
      3: return lo - 32'd1;
      4: return hi + 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    // Write into leaf 1
    step(1'b0, 1'b1, 1'b0, 32'hF800_2004, 32'hDEAD_BEEF);
    idle(3);
    // Read leaf 3, hold across idle cycles
    step(1'b0, 1'b0, 1'b1, 32'h0000_0010, '0);
    idle(12);
    // Back-to-back reads to leaves 0, 5, 4
    step(1'b0, 1'b0, 1'b1, 32'hF800_0100, '0);
    step(1'b0, 1'b0, 1'b1, 32'h1000_1630, '0);
    step(1'b0, 1'b0, 1'b1, 32'h0010_0000, '0);
    idle(6);
    // Read inside the gap between leaf 1 and leaf 2
    step(1'b0, 1'b0, 1'b1, 32'hF800_2200, '0);
    idle(5);
    // Five more misses drive the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h2000_0000 + i, $urandom);
    idle(2);
    // Simultaneous wr+rd, one hit and one miss address
    step(1'b0, 1'b1, 1'b1, 32'hF800_23FF, 32'h1122_3344);
    step(1'b0, 1'b1, 1'b1, 32'hF800_2400, 32'h5566_7788);
    idle(5);
    // Reset two cycles after a read is launched
    step(1'b0, 1'b0, 1'b1, 32'hF800_0000, '0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(8);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 80) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
           pick_addr(), $urandom);
    end
    idle(RL + 4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bridge_router.md
Name: bridge_router

Overview:
- Parametrised successor to the fixed six-leaf bridge fan-out. Decodes the APF bridge bus (32-bit address, wr/rd strobes) onto NUM_LEAVES leaves using per-leaf inclusive address ranges.
- Registers all leaf-side strobes.
- Pipelines read returns with a programmable leaf read latency.
- Answers unmapped accesses with a fixed word and counts them for debug.
- Sits between the bridge input and the core leaves (cmd, dataslot, id, rom, dip, hs, ...).

Parameters:
- NUM_LEAVES, 6, number of leaves (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- ADDR_FROM, {NUM_LEAVES{32'h0}}, packed array; inclusive lower bound per leaf.
- ADDR_TO, {NUM_LEAVES{32'h0}}, packed array; inclusive upper bound per leaf.
- READ_LATENCY, 2, cycles from leaf_rd to valid leaf_rd_data (1..8).
- UNMAPPED_DATA, 32'h0000_0000, read value returned for an unmapped address.
- ERR_CNT_W, 16, width of the unmapped-access counter.

Ports:
- clk, in, 1, bridge clock (clk_74a domain).
- reset, in, 1, synchronous active-high reset.
- bridge_addr, in, ADDR_W, bridge address.
- bridge_wr, in, 1, write strobe (single-cycle).
- bridge_wr_data, in, DATA_W, write data.
- bridge_rd, in, 1, read strobe (single-cycle).
- bridge_rd_data, out, DATA_W, registered read return.
- leaf_addr, out, ADDR_W, registered broadcast address.
- leaf_wr_data, out, DATA_W, registered broadcast write data.
- leaf_wr, out, NUM_LEAVES, one-hot registered write strobes.
- leaf_rd, out, NUM_LEAVES, one-hot registered read strobes.
- leaf_rd_data, in, NUM_LEAVES*DATA_W, per-leaf read data; leaf i occupies slice i.
- unmapped_count, out, ERR_CNT_W, saturating count of unmapped accesses.
- last_unmapped_addr, out, ADDR_W, address of the most recent unmapped access.

Behaviour:
- Reset: all outputs are 0, and the read pipeline is cleared. Any in-flight read is dropped, with no capture and no count.
- Decode (combinational): leaf i hits when ADDR_FROM[i] <= bridge_addr <= ADDR_TO[i], compared unsigned. On overlapping ranges, the lowest index wins. No hit means unmapped.
- Write path, 1-cycle latency: a write at edge T produces the following at T+1.
  - leaf_addr and leaf_wr_data take the registered values.
  - leaf_wr[hit] is high for exactly 1 cycle.
  - leaf_addr and leaf_wr_data update on every cycle that has a wr or rd strobe. Otherwise they hold.
- Read path:
  - bridge_rd at T produces leaf_rd[hit] at T+1.
  - {valid, index, unmapped} enter a shift pipeline of depth READ_LATENCY.
  - At T+1+READ_LATENCY the router captures leaf_rd_data[index], or UNMAPPED_DATA if unmapped.
  - bridge_rd_data is valid from T+2+READ_LATENCY and holds until the next capture.
- Back-to-back reads on consecutive cycles are fully pipelined and captured in order.
- Unmapped access:
  - No leaf strobe is driven.
  - last_unmapped_addr is loaded at T+1.
  - unmapped_count increments by 1 and saturates at all-ones. The increment is per cycle, not per strobe.
- Simultaneous wr and rd in one cycle (protocol violation): both are forwarded to their hit leaves. Each is handled independently. The counter increments by 1 if either misses.
- Counter at saturation: it holds; last_unmapped_addr still updates.

Optional Feature:
- Macro: BRIDGE_ROUTER_BYTESWAP_EN.
- Defined: leaf_wr_data and the captured read data are byte-reversed, so byte 0 maps to byte DATA_W/8-1. This gives little-endian leaves on the big-endian bridge. UNMAPPED_DATA is also returned swapped.
- Undefined: data passes unmodified. The address is never swapped.

Test Plan:
- Leaf ranges {F8000000-F8001FFF, F8002000-F80020FF, F8002380-F80023FF, 0-FFFFF, 100000-100000, 10001620-1000166F}. Write F8002004=DEADBEEF, then one cycle later leaf_wr=6'b000010 for exactly 1 cycle, with leaf_addr=F8002004 and leaf_wr_data=DEADBEEF.
- READ_LATENCY=2, leaf 3 returns 12345678. Read 00000010 at T, then leaf_rd=6'b001000 at T+1 and bridge_rd_data=12345678 from T+4, held for 10 idle cycles.
- Reads at T, T+1, T+2 to leaves 0, 5, 4 returning A, B, C: bridge_rd_data=A at T+4, B at T+5, C at T+6.
- Read F8002200 (gap): no leaf strobe, bridge_rd_data=00000000 at T+4, unmapped_count=1, last_unmapped_addr=F8002200. With ERR_CNT_W=2, 5 misses leave count=3.
- Reset asserted at T+2 of an in-flight read: all outputs are 0 at T+3. No capture occurs after reset deasserts, and bridge_rd_data stays 0.
- With BRIDGE_ROUTER_BYTESWAP_EN: writing 11223344 drives leaf_wr_data=44332211, and a leaf returning AABBCCDD yields bridge_rd_data=DDCCBBAA.
